// File: rtl/multi_sonar_ranger.sv
// Round-robin ultrasonic ranger: triggers one sensor at a time, times its
// echo in us ticks and converts the width to cm (58 us per cm).
module multi_sonar_ranger #(
  parameter int CLK_HZ     = 50000000,
  parameter int NUM_CH     = 4,
  parameter int DIST_W     = 9,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 60000,
  parameter int NEAR_CM    = 10
) (
  input  logic                       clk_50m,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          echo,
  output logic [NUM_CH-1:0]          trig,
  output logic [NUM_CH*DIST_W-1:0]   distance,
  output logic [NUM_CH-1:0]          timeout,
  output logic [NUM_CH-1:0]          near,
  output logic                       valid,
  output logic [2:0]                 ch_id
);

  localparam int PRE  = CLK_HZ / 1000000;
  localparam int PW   = (PRE > 1) ? $clog2(PRE) : 1;
  localparam int TM1  = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
  localparam int TMAX = (TM1 > TRIG_US) ? TM1 : TRIG_US;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, TRIG, WAIT_RISE, MEASURE, DONE, GAP
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]     pre_cnt;
  logic              us_tick;
  logic [NUM_CH-1:0] s1, s2, s3;
  logic [NUM_CH-1:0] rise, fall;
  logic              cur_rise, cur_fall;
  logic [TW-1:0]     tcnt;
  logic [5:0]        sub;
  logic [DIST_W-1:0] cm;
  logic              to_flag;

  assign us_tick = (pre_cnt == PW'(PRE - 1));

  always_ff @(posedge clk_50m) begin
    if (rst || us_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= echo;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  always_comb begin
    cur_rise = 1'b0;
    cur_fall = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_id == 3'(i)) begin
        cur_rise = rise[i];
        cur_fall = fall[i];
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (enable && us_tick) state_nx = TRIG;
      TRIG:
        if (us_tick && tcnt == TW'(TRIG_US - 1))
          state_nx = WAIT_RISE;
      WAIT_RISE:
        if (cur_rise)
          state_nx = MEASURE;
        else if (us_tick && tcnt == TW'(TIMEOUT_US - 1))
          state_nx = DONE;
      MEASURE:
        if (cur_fall || (us_tick && tcnt == TW'(TIMEOUT_US - 1)))
          state_nx = DONE;
      DONE:
        state_nx = GAP;
      GAP:
        if (us_tick && tcnt == TW'(GAP_US - 1))
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_comb begin
    trig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state == TRIG && ch_id == 3'(i)) trig[i] = 1'b1;
    end
  end

  // Ticks on the fall cycle still count, so an N us echo sees exactly N ticks.
  always_ff @(posedge clk_50m) begin
    if (rst) begin
      tcnt     <= '0;
      sub      <= '0;
      cm       <= '0;
      to_flag  <= 1'b0;
      valid    <= 1'b0;
      ch_id    <= '0;
      distance <= '0;
      timeout  <= '0;
      near     <= '0;
    end else begin
      valid <= (state == DONE);
      if (state != state_nx) tcnt <= '0;
      else if (us_tick)      tcnt <= tcnt + 1'b1;
      if (state == WAIT_RISE) begin
        sub <= '0;
        cm  <= '0;
      end else if (state == MEASURE && us_tick) begin
        if (sub == 6'd57) begin
          sub <= '0;
          if (cm != '1) cm <= cm + 1'b1;
        end else begin
          sub <= sub + 1'b1;
        end
      end
      if (state_nx == DONE && state != DONE)
        to_flag <= !(state == MEASURE && cur_fall);
      if (state == DONE) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_id == 3'(i)) begin
            distance[i*DIST_W +: DIST_W] <= to_flag ? '1 : cm;
            timeout[i] <= to_flag;
            near[i]    <= !to_flag && (cm < DIST_W'(NEAR_CM));
          end
        end
      end
      if (state == GAP && state_nx == IDLE) begin
        if (ch_id == 3'(NUM_CH - 1)) ch_id <= '0;
        else                          ch_id <= ch_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_sonar_ranger.sv
// Directed bench for multi_sonar_ranger, scaled to 10 cycles per us
// so a full four-channel scan stays short.
`timescale 1ns/1ps
module tb_multi_sonar_ranger;

  localparam int CLK_HZ     = 10000000;
  localparam int NUM_CH     = 4;
  localparam int DIST_W     = 9;
  localparam int TRIG_US    = 10;
  localparam int TIMEOUT_US = 1000;
  localparam int GAP_US     = 20;
  localparam int NEAR_CM    = 10;
  localparam int PRE        = CLK_HZ / 1000000;
  localparam int TRIG_CYC   = TRIG_US * PRE;

  logic                     clk_50m = 1'b0;
  logic                     rst = 1'b1;
  logic                     enable = 1'b0;
  logic [NUM_CH-1:0]        echo = '0;
  logic [NUM_CH-1:0]        trig;
  logic [NUM_CH*DIST_W-1:0] distance;
  logic [NUM_CH-1:0]        timeout;
  logic [NUM_CH-1:0]        near;
  logic                     valid;
  logic [2:0]               ch_id;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  multi_sonar_ranger #(
    .CLK_HZ(CLK_HZ), .NUM_CH(NUM_CH), .DIST_W(DIST_W),
    .TRIG_US(TRIG_US), .TIMEOUT_US(TIMEOUT_US),
    .GAP_US(GAP_US), .NEAR_CM(NEAR_CM)
  ) dut (
    .clk_50m(clk_50m), .rst(rst), .enable(enable),
    .echo(echo), .trig(trig), .distance(distance),
    .timeout(timeout), .near(near), .valid(valid),
    .ch_id(ch_id)
  );

  always #5 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  function automatic logic [DIST_W-1:0] dist_of(input int c);
    return distance[c*DIST_W +: DIST_W];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (trig !== '0) begin
      n_bad++; $display("FAIL reset_trig: got %b want 0", trig);
    end
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", valid);
    end
    n_cmp++;
    if (distance !== '0) begin
      n_bad++; $display("FAIL reset_distance: got %h want 0", distance);
    end
    n_cmp++;
    if (timeout !== '0) begin
      n_bad++; $display("FAIL reset_timeout: got %b want 0", timeout);
    end
    n_cmp++;
    if (near !== '0) begin
      n_bad++; $display("FAIL reset_near: got %b want 0", near);
    end
    n_cmp++;
    if (ch_id !== 3'd0) begin
      n_bad++; $display("FAIL reset_ch_id: got %0d want 0", ch_id);
    end
  endtask

  // mode 0: pulse of w_cyc cycles, 1: never rises, 2: stuck high
  task automatic run_shot(input int c, input int mode, input int w_cyc,
                          input int exp_dist, input bit exp_to,
                          input bit exp_near, input int noise_ch,
                          input string nm);
    logic [NUM_CH-1:0] oh;
    bit seen;
    int t0;
    int width;
    oh = NUM_CH'(1 << c);
    seen = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (trig !== '0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!seen || trig !== oh) begin
      n_bad++; $display("FAIL %s trig_sel: got %b want %b", nm, trig, oh);
    end
    t0 = cyc;
    width = 0;
    while (trig === oh && width < 5000) begin
      width++;
      tick();
    end
    n_cmp++;
    if (width != TRIG_CYC || trig !== '0) begin
      n_bad++;
      $display("FAIL %s trig_width: got %0d cycles then %b want %0d then 0",
               nm, width, trig, TRIG_CYC);
    end
    repeat (37) tick();
    if (mode == 0) begin
      echo[c] = 1'b1;
      if (noise_ch >= 0) echo[noise_ch] = 1'b1;
      repeat (w_cyc) tick();
      echo[c] = 1'b0;
      if (noise_ch >= 0) echo[noise_ch] = 1'b0;
    end else if (mode == 2) begin
      echo[c] = 1'b1;
    end
    seen = 1'b0;
    for (int k = 0; k < 4 * TIMEOUT_US * PRE; k++) begin
      if (valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL %s valid_seen: got none want pulse", nm);
    end
    if (mode == 1) begin
      n_cmp++;
      if (cyc - t0 != (TRIG_US + TIMEOUT_US) * PRE + 1) begin
        n_bad++;
        $display("FAIL %s valid_time: got %0d cycles want %0d",
                 nm, cyc - t0, (TRIG_US + TIMEOUT_US) * PRE + 1);
      end
    end
    n_cmp++;
    if (ch_id !== 3'(c)) begin
      n_bad++; $display("FAIL %s ch_id: got %0d want %0d", nm, ch_id, c);
    end
    n_cmp++;
    if (dist_of(c) !== DIST_W'(exp_dist)) begin
      n_bad++;
      $display("FAIL %s distance: got %0d want %0d", nm, dist_of(c), exp_dist);
    end
    n_cmp++;
    if (timeout[c] !== exp_to) begin
      n_bad++;
      $display("FAIL %s timeout: got %b want %b", nm, timeout[c], exp_to);
    end
    n_cmp++;
    if (near[c] !== exp_near) begin
      n_bad++;
      $display("FAIL %s near: got %b want %b", nm, near[c], exp_near);
    end
    tick();
    n_cmp++;
    if (valid !== 1'b0) begin
      n_bad++; $display("FAIL %s valid_pulse: got %b want 0", nm, valid);
    end
    if (mode == 2) echo[c] = 1'b0;
  endtask

  task automatic test_scan();
    rst = 1'b0;
    enable = 1'b1;
    run_shot(0, 0, 580 * PRE, 10, 1'b0, 1'b0, -1, "ch0_580us");
    run_shot(1, 0, 290 * PRE, 5, 1'b0, 1'b1, 0, "ch1_290us");
    run_shot(2, 1, 0, 511, 1'b1, 1'b0, -1, "ch2_no_echo");
    run_shot(3, 2, 0, 511, 1'b1, 1'b0, -1, "ch3_stuck");
    n_cmp++;
    if (dist_of(0) !== 9'd10 || dist_of(1) !== 9'd5 ||
        dist_of(2) !== 9'd511) begin
      n_bad++;
      $display("FAIL others_kept: got %0d %0d %0d want 10 5 511",
               dist_of(0), dist_of(1), dist_of(2));
    end
    n_cmp++;
    if (timeout !== 4'b1100 || near !== 4'b0010) begin
      n_bad++;
      $display("FAIL flags_kept: got to=%b near=%b want 1100 0010",
               timeout, near);
    end
  endtask

  task automatic test_zero_width();
    run_shot(0, 0, 3, 0, 1'b0, 1'b1, -1, "ch0_zero_width");
  endtask

  task automatic test_reset_mid_measure();
    int k;
    k = 0;
    while (trig !== 4'b0010 && k < 2000) begin
      k++;
      tick();
    end
    n_cmp++;
    if (trig !== 4'b0010) begin
      n_bad++; $display("FAIL rst_mid_trig1: got %b want 0010", trig);
    end
    k = 0;
    while (trig !== '0 && k < 2000) begin
      k++;
      tick();
    end
    repeat (10) tick();
    echo[1] = 1'b1;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (trig !== '0 || valid !== 1'b0 || ch_id !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_mid_ctrl: got trig=%b valid=%b ch=%0d want 0 0 0",
               trig, valid, ch_id);
    end
    n_cmp++;
    if (distance !== '0 || timeout !== '0 || near !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_results: got d=%h to=%b near=%b want 0",
               distance, timeout, near);
    end
    echo[1] = 1'b0;
    rst = 1'b0;
    k = 0;
    while (trig === '0 && k < 50) begin
      k++;
      tick();
    end
    n_cmp++;
    if (trig !== 4'b0001 || k > PRE + 2) begin
      n_bad++;
      $display("FAIL rst_restart: got trig=%b after %0d want 0001 within %0d",
               trig, k, PRE + 2);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_zero_width();
    test_reset_mid_measure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
